mesh_lkahead_route_checker: RTL and testbench

// Input-port checker at the receiving router for look-ahead XY routing on a 2D mesh. Recomputes
// the XY output port for each arriving header flit at this router.

---
 rtl/mesh_lkahead_route_checker.sv | 140 ++++++++++++++
 tb/tb_mesh_lkahead_route_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mesh_lkahead_route_checker.sv
// Receiving-side checker for look-ahead XY routing: recomputes the XY output port for each
// header flit, compares it with the upstream look-ahead port, and tracks framing violations.
module mesh_lkahead_route_checker #(
    parameter int NX  = 4,
    parameter int NY  = 4,
    parameter int RXw = $clog2(NX),
    parameter int RYw = $clog2(NY)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic [RXw-1:0] current_rx,
    input  logic [RYw-1:0] current_ry,
    input  logic           flit_wr,
    input  logic           hdr_flg,
    input  logic           tail_flg,
    input  logic [RXw-1:0] dest_ex,
    input  logic [RYw-1:0] dest_ey,
    input  logic [2:0]     lkdestport,
    output logic           route_err,
    output logic           proto_err,
    output logic [15:0]    err_cnt,
    output logic           trigger,
    output logic [31:0]    trace_signal
);

    typedef enum logic [2:0] {
        P_LOCAL = 3'd0,
        P_EAST  = 3'd1,
        P_NORTH = 3'd2,
        P_WEST  = 3'd3,
        P_SOUTH = 3'd4
    } port_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        route_err_q, route_err_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        trigger_q, trigger_d;
    logic [31:0] trace_q, trace_d;

    port_e       exp_port;
    logic        route_hit;
    logic        proto_hit;
    logic [1:0]  err_inc;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_next;

    // X dimension is resolved before Y; north is toward smaller y.
    always_comb begin
        exp_port = P_LOCAL;
        if (dest_ex > current_rx) begin
            exp_port = P_EAST;
        end else if (dest_ex < current_rx) begin
            exp_port = P_WEST;
        end else if (dest_ey < current_ry) begin
            exp_port = P_NORTH;
        end else if (dest_ey > current_ry) begin
            exp_port = P_SOUTH;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_hit = flit_wr && hdr_flg && (lkdestport != 3'(exp_port));
        proto_hit = 1'b0;

        if (flit_wr) begin
            if (state_q == S_IDLE) begin
                proto_hit = !hdr_flg;
            end else begin
                proto_hit = hdr_flg;
            end

            // A header in mid-packet is still a header: it restarts the packet.
            if (hdr_flg) begin
                state_d = tail_flg ? S_IDLE : S_IN_PKT;
            end else if (state_q == S_IN_PKT && tail_flg) begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        err_inc  = {1'b0, route_hit} + {1'b0, proto_hit};
        cnt_sum  = {1'b0, err_cnt_q} + 17'(err_inc);
        cnt_next = cnt_sum[16] ? '1 : cnt_sum[15:0];

        route_err_d = 1'b0;
        proto_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        trigger_d   = trigger_q;
        trace_d     = trace_q;

        if (clear) begin
            err_cnt_d = '0;
            trigger_d = 1'b0;
            trace_d   = '0;
        end else begin
            route_err_d = route_hit;
            proto_err_d = proto_hit;
            err_cnt_d   = cnt_next;
            if (!trigger_q && (route_hit || proto_hit)) begin
                trigger_d = 1'b1;
                trace_d   = {3'(exp_port), lkdestport, route_hit, proto_hit,
                             4'(dest_ex), 4'(dest_ey), cnt_next};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            route_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            err_cnt_q   <= '0;
            trigger_q   <= 1'b0;
            trace_q     <= '0;
        end else begin
            state_q     <= state_d;
            route_err_q <= route_err_d;
            proto_err_q <= proto_err_d;
            err_cnt_q   <= err_cnt_d;
            trigger_q   <= trigger_d;
            trace_q     <= trace_d;
        end
    end

    assign route_err    = route_err_q;
    assign proto_err    = proto_err_q;
    assign err_cnt      = err_cnt_q;
    assign trigger      = trigger_q;
    assign trace_signal = trace_q;

endmodule

// File: tb/tb_mesh_lkahead_route_checker.sv
// Directed bench for mesh_lkahead_route_checker with hand-computed expectations (router at 1,1).
module tb_mesh_lkahead_route_checker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [1:0]  current_rx;
    logic [1:0]  current_ry;
    logic        flit_wr;
    logic        hdr_flg;
    logic        tail_flg;
    logic [1:0]  dest_ex;
    logic [1:0]  dest_ey;
    logic [2:0]  lkdestport;
    logic        route_err;
    logic        proto_err;
    logic [15:0] err_cnt;
    logic        trigger;
    logic [31:0] trace_signal;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mesh_lkahead_route_checker #(.NX(4), .NY(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .current_rx   (current_rx),
        .current_ry   (current_ry),
        .flit_wr      (flit_wr),
        .hdr_flg      (hdr_flg),
        .tail_flg     (tail_flg),
        .dest_ex      (dest_ex),
        .dest_ey      (dest_ey),
        .lkdestport   (lkdestport),
        .route_err    (route_err),
        .proto_err    (proto_err),
        .err_cnt      (err_cnt),
        .trigger      (trigger),
        .trace_signal (trace_signal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic r, input logic p,
                             input logic [15:0] cnt, input logic trg);
        check_eq({tag, ".route"}, 32'(route_err), 32'(r));
        check_eq({tag, ".proto"}, 32'(proto_err), 32'(p));
        check_eq({tag, ".cnt"},   32'(err_cnt),   32'(cnt));
        check_eq({tag, ".trig"},  32'(trigger),   32'(trg));
    endtask

    task automatic send(input logic h, input logic t, input logic [1:0] dx, input logic [1:0] dy,
                        input logic [2:0] lk, input logic clr);
        @(negedge clk);
        flit_wr    = 1'b1;
        hdr_flg    = h;
        tail_flg   = t;
        dest_ex    = dx;
        dest_ey    = dy;
        lkdestport = lk;
        clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        flit_wr = 1'b0;
        hdr_flg = 1'b0;
        tail_flg = 1'b0;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; current_rx = 2'd1; current_ry = 2'd1;
        flit_wr = 1'b0; hdr_flg = 1'b0; tail_flg = 1'b0;
        dest_ex = '0; dest_ey = '0; lkdestport = '0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 1'b0, 16'd0, 1'b0);
        check_eq("reset.trace", trace_signal, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        send(1, 1, 2'd3, 2'd1, 3'd1, 0);           // EAST, matches
        check_out("single_ok", 0, 0, 16'd0, 0);

        send(1, 0, 2'd1, 2'd0, 3'd4, 0);           // expected NORTH, carried SOUTH
        check_out("route_mis", 1, 0, 16'd1, 1);
        check_eq("route_mis.trace", trace_signal, 32'h5210_0001);

        send(0, 1, 2'd0, 2'd0, 3'd0, 0);
        check_out("tail_ok", 0, 0, 16'd1, 1);

        send(0, 0, 2'd0, 2'd0, 3'd0, 0);           // body while idle
        check_out("body_idle", 0, 1, 16'd2, 1);
        check_eq("body_idle.trace", trace_signal, 32'h5210_0001);

        send(1, 0, 2'd0, 2'd1, 3'd3, 0);           // WEST, matches
        check_out("hdr_west", 0, 0, 16'd2, 1);
        send(0, 0, 2'd0, 2'd0, 3'd0, 0);
        check_out("body_in", 0, 0, 16'd2, 1);
        send(1, 0, 2'd1, 2'd2, 3'd4, 0);           // SOUTH matches, but header mid-packet
        check_out("hdr_in_pkt", 0, 1, 16'd3, 1);

        idle(0);
        check_out("idle", 0, 0, 16'd3, 1);

        send(1, 1, 2'd1, 2'd1, 3'd7, 0);           // illegal port code, header mid-packet
        check_out("both_lk7", 1, 1, 16'd5, 1);
        send(1, 1, 2'd1, 2'd1, 3'd0, 0);           // LOCAL, back in idle
        check_out("local_ok", 0, 0, 16'd5, 1);

        idle(1);
        check_out("clear", 0, 0, 16'd0, 0);
        check_eq("clear.trace", trace_signal, 32'h0);

        send(0, 0, 2'd2, 2'd3, 3'd1, 0);
        check_out("proto_first", 0, 1, 16'd1, 1);
        check_eq("proto_first.trace", trace_signal, 32'h2523_0001);

        send(1, 0, 2'd1, 2'd0, 3'd1, 1);           // mismatch dropped by clear
        check_out("clr_drop", 0, 0, 16'd0, 0);
        check_eq("clr_drop.trace", trace_signal, 32'h0);

        send(1, 1, 2'd0, 2'd0, 3'd3, 0);           // FSM advanced during clear
        check_out("clr_fsm", 0, 1, 16'd1, 1);
        check_eq("clr_fsm.trace", trace_signal, 32'h6D00_0001);

        idle(1);
        send(1, 0, 2'd1, 2'd1, 3'd0, 0);
        check_out("sat_start", 0, 0, 16'd0, 0);
        for (int unsigned i = 0; i < 32767; i++) begin
            send(1, 0, 2'd1, 2'd1, 3'd1, 0);
        end
        check_out("sat_fffe", 1, 1, 16'hFFFE, 1);
        check_eq("sat_fffe.trace", trace_signal, 32'h0711_0002);
        send(1, 0, 2'd1, 2'd1, 3'd1, 0);
        check_out("sat_ffff", 1, 1, 16'hFFFF, 1);
        send(1, 0, 2'd1, 2'd1, 3'd1, 0);
        check_out("sat_hold", 1, 1, 16'hFFFF, 1);

        send(1, 0, 2'd1, 2'd1, 3'd0, 0);
        @(negedge clk);
        flit_wr = 1'b0;
        reset   = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 16'd0, 0);
        check_eq("async_rst.trace", trace_signal, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        send(0, 1, 2'd0, 2'd0, 3'd0, 0);
        check_out("rst_tail", 0, 1, 16'd1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
